// File: rtl/u409_tack_pkg.sv
// u409_tack_pkg: shared types and requester indices for the U409 cycle-termination arbiter.
package u409_tack_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRIVE   = 2'd1,
    RELEASE = 2'd2,
    TURN    = 2'd3
  } tack_state_e;

  localparam int REQ_ROM    = 0;
  localparam int REQ_IRQ    = 1;
  localparam int REQ_AC     = 2;
  localparam int REQ_RTC    = 3;
  localparam int REQ_FLASH  = 4;
  localparam int REQ_CIA    = 5;
  localparam int REQ_DLY    = 7;

  localparam int COLL_CNT_W = 8;

endpackage

// File: rtl/u409_prio_pick.sv
// u409_prio_pick: combinational lowest-index one-hot picker with a multi-hit flag.
module u409_prio_pick #(
  parameter int N_REQ = 8
) (
  input  logic [N_REQ-1:0] cand,
  output logic [N_REQ-1:0] onehot,
  output logic             multi
);

  localparam logic [N_REQ-1:0] ONE = {{(N_REQ-1){1'b0}}, 1'b1};

  // Two's-complement trick isolates the lowest set bit; anything left over is a loser.
  assign onehot = cand & (~cand + ONE);
  assign multi  = |(cand & ~onehot);

endmodule

// File: rtl/u409_tack_arbiter.sv
// u409_tack_arbiter: single owner of the MC68040 TACKn/TBIn/TCIn drivers in U409.
// Grants one termination per bus cycle, sequences drive -> negate -> tristate -> turnaround,
// and counts collisions. The pad tristates are formed from TACK_OE in the pad wrapper.
// Optional feature macro: U409_TACK_TEA_EN (adds TEA_OUT; a grant to TEA_IDX ends in a bus error).
module u409_tack_arbiter
  import u409_tack_pkg::*;
#(
  parameter int               N_REQ        = 8,
  parameter logic [N_REQ-1:0] NOCACHE_MASK = {{(N_REQ-1){1'b1}}, 1'b0},
  parameter int               TURN_CYCLES  = 1
`ifdef U409_TACK_TEA_EN
  ,
  parameter int               TEA_IDX      = N_REQ-1
`endif
) (
  input  logic                  CLK40_IN,
  input  logic                  DELAYED_TACK_RST,
  input  logic                  TSn,
  input  logic [N_REQ-1:0]      REQ,
  output logic                  TACK_OE,
  output logic                  TACK_OUT,
  output logic                  TBI_OUT,
  output logic                  TCI_OUT,
  output logic [N_REQ-1:0]      GRANT,
  output logic                  BUSY,
  output logic                  COLLISION,
`ifdef U409_TACK_TEA_EN
  output logic                  TEA_OUT,
`endif
  output logic [COLL_CNT_W-1:0] COLL_CNT
);

  localparam logic [1:0] TURN_LAST = 2'(TURN_CYCLES - 1);

  tack_state_e      state, state_n;
  logic [N_REQ-1:0] pend, pend_n, cand, pick, grant_n;
  logic             multi, oe_n, tack_n, coll_n;
  logic [1:0]       turn_cnt, turn_n;
`ifdef U409_TACK_TEA_EN
  logic             tea_n;
`endif

  assign cand = pend | REQ;

  u409_prio_pick #(.N_REQ(N_REQ)) u_pick (
    .cand   (cand),
    .onehot (pick),
    .multi  (multi)
  );

  // Next-state and next-output decode for the termination sequence.
  always_comb begin
    state_n = state;
    pend_n  = pend | REQ;
    grant_n = GRANT;
    oe_n    = TACK_OE;
    tack_n  = TACK_OUT;
    coll_n  = 1'b0;
    turn_n  = turn_cnt;
`ifdef U409_TACK_TEA_EN
    tea_n   = TEA_OUT;
`endif
    case (state)
      IDLE: begin
        if (!TSn && (pend != '0) && (REQ == '0)) begin
          // A new cycle started while only old requests were pending: they are stale.
          pend_n = '0;
          coll_n = 1'b1;
        end else if (cand != '0) begin
          grant_n = pick;
          oe_n    = 1'b1;
          pend_n  = '0;
          coll_n  = multi;
          state_n = DRIVE;
`ifdef U409_TACK_TEA_EN
          if (pick[TEA_IDX]) tea_n = 1'b0;
          else               tack_n = 1'b0;
`else
          tack_n  = 1'b0;
`endif
        end
      end
      DRIVE: begin
        // Actively negate before tristating so the line never floats low.
        tack_n  = 1'b1;
`ifdef U409_TACK_TEA_EN
        tea_n   = 1'b1;
`endif
        state_n = RELEASE;
      end
      RELEASE: begin
        oe_n    = 1'b0;
        turn_n  = 2'd0;
        state_n = TURN;
      end
      TURN: begin
        if (turn_cnt == TURN_LAST) begin
          grant_n = '0;
          state_n = IDLE;
        end else begin
          turn_n = turn_cnt + 2'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and registered outputs; reset releases the pads without waiting for a clock.
  always_ff @(posedge CLK40_IN or posedge DELAYED_TACK_RST) begin
    if (DELAYED_TACK_RST) begin
      state     <= IDLE;
      pend      <= '0;
      GRANT     <= '0;
      TACK_OE   <= 1'b0;
      TACK_OUT  <= 1'b1;
      COLLISION <= 1'b0;
      COLL_CNT  <= '0;
      turn_cnt  <= 2'd0;
`ifdef U409_TACK_TEA_EN
      TEA_OUT   <= 1'b1;
`endif
    end else begin
      state     <= state_n;
      pend      <= pend_n;
      GRANT     <= grant_n;
      TACK_OE   <= oe_n;
      TACK_OUT  <= tack_n;
      COLLISION <= coll_n;
      turn_cnt  <= turn_n;
      if (coll_n && (COLL_CNT != '1)) COLL_CNT <= COLL_CNT + 1'b1;
`ifdef U409_TACK_TEA_EN
      TEA_OUT   <= tea_n;
`endif
    end
  end

  assign BUSY    = (state != IDLE);
  assign TBI_OUT = TACK_OUT;
  // TACK_OUT is 1 whenever the pads are released, so TCI follows it back to 1.
  assign TCI_OUT = TACK_OUT | ~|(GRANT & NOCACHE_MASK);

endmodule

// File: tb/tb_u409_tack_arbiter.sv
// tb_u409_tack_arbiter: directed vectors with hand-computed expectations.
`timescale 1ns/1ps
module tb_u409_tack_arbiter;

  logic       CLK40_IN = 1'b0;
  logic       DELAYED_TACK_RST;
  logic       TSn;
  logic [7:0] REQ;
  logic       TACK_OE, TACK_OUT, TBI_OUT, TCI_OUT, BUSY, COLLISION;
  logic [7:0] GRANT, COLL_CNT;
`ifdef U409_TACK_TEA_EN
  logic       TEA_OUT;
`endif

  int total = 0;
  int bad   = 0;

  always #12.5 CLK40_IN = ~CLK40_IN;

  u409_tack_arbiter dut (
    .CLK40_IN         (CLK40_IN),
    .DELAYED_TACK_RST (DELAYED_TACK_RST),
    .TSn              (TSn),
    .REQ              (REQ),
    .TACK_OE          (TACK_OE),
    .TACK_OUT         (TACK_OUT),
    .TBI_OUT          (TBI_OUT),
    .TCI_OUT          (TCI_OUT),
    .GRANT            (GRANT),
    .BUSY             (BUSY),
    .COLLISION        (COLLISION),
`ifdef U409_TACK_TEA_EN
    .TEA_OUT          (TEA_OUT),
`endif
    .COLL_CNT         (COLL_CNT)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle 1 ns past it.
  task automatic tick();
    @(posedge CLK40_IN);
    #1;
  endtask

  // Pads-released, idle output set.
  task automatic chk_idle(input string tag);
    chk({tag, ".oe"},   32'(TACK_OE),  32'h0);
    chk({tag, ".tack"}, 32'(TACK_OUT), 32'h1);
    chk({tag, ".tbi"},  32'(TBI_OUT),  32'h1);
    chk({tag, ".tci"},  32'(TCI_OUT),  32'h1);
    chk({tag, ".gnt"},  32'(GRANT),    32'h0);
    chk({tag, ".busy"}, 32'(BUSY),     32'h0);
  endtask

  initial begin
    DELAYED_TACK_RST = 1'b1;
    TSn = 1'b1;
    REQ = 8'h00;
    #3;
    chk_idle("rst");
    chk("rst.coll", 32'(COLLISION), 32'h0);
    chk("rst.cnt",  32'(COLL_CNT),  32'h0);
    tick();
    DELAYED_TACK_RST = 1'b0;
    repeat (3) tick();

    // 1: ROM single pulse, cacheable
    REQ = 8'h01; tick();
    chk("t1.tack0", 32'(TACK_OUT), 32'h0);
    chk("t1.oe0",   32'(TACK_OE),  32'h1);
    chk("t1.tbi0",  32'(TBI_OUT),  32'h0);
    chk("t1.tci0",  32'(TCI_OUT),  32'h1);
    chk("t1.gnt0",  32'(GRANT),    32'h01);
    chk("t1.coll",  32'(COLLISION), 32'h0);
    REQ = 8'h00; tick();
    chk("t1.tack1", 32'(TACK_OUT), 32'h1);
    chk("t1.oe1",   32'(TACK_OE),  32'h1);
    tick();
    chk("t1.oe2",   32'(TACK_OE),  32'h0);
    chk("t1.gnt2",  32'(GRANT),    32'h01);
    chk("t1.busy2", 32'(BUSY),     32'h1);
    tick();
    chk_idle("t1.end");

    // 2: CIA is non-cacheable
    REQ = 8'h20; tick();
    chk("t2.tack", 32'(TACK_OUT), 32'h0);
    chk("t2.tci",  32'(TCI_OUT),  32'h0);
    chk("t2.gnt0", 32'(GRANT),    32'h20);
    REQ = 8'h00; tick();
    chk("t2.tci1", 32'(TCI_OUT),  32'h1);
    chk("t2.gnt1", 32'(GRANT),    32'h20);
    tick();
    chk("t2.gnt2", 32'(GRANT),    32'h20);
    tick();
    chk("t2.gnt3", 32'(GRANT),    32'h00);

    // 3: simultaneous IRQ+RTC, loser discarded
    REQ = 8'h0A; tick();
    chk("t3.gnt",  32'(GRANT),     32'h02);
    chk("t3.coll", 32'(COLLISION), 32'h1);
    chk("t3.cnt",  32'(COLL_CNT),  32'h1);
    chk("t3.tack", 32'(TACK_OUT),  32'h0);
    REQ = 8'h00; tick();
    chk("t3.coll1", 32'(COLLISION), 32'h0);
    repeat (3) tick();
    chk_idle("t3.nosecond");

    // 4: IRQ during RELEASE -> next TACK exactly 4 edges after the first
    REQ = 8'h02; tick();
    chk("t4.tackA", 32'(TACK_OUT), 32'h0);
    REQ = 8'h00; tick();
    REQ = 8'h02; tick();
    REQ = 8'h00; tick();
    chk("t4.gap",   32'(TACK_OUT), 32'h1);
    tick();
    chk("t4.tackB", 32'(TACK_OUT), 32'h0);
    chk("t4.gntB",  32'(GRANT),    32'h02);
    chk("t4.cnt",   32'(COLL_CNT), 32'h1);
    repeat (3) tick();

    // Stale: request latched in TURN, then TSn low in IDLE with no REQ
    REQ = 8'h04; tick();
    REQ = 8'h00; tick(); tick();
    REQ = 8'h08; tick();
    REQ = 8'h00; TSn = 1'b0; tick();
    chk("st.coll", 32'(COLLISION), 32'h1);
    chk("st.cnt",  32'(COLL_CNT),  32'h2);
    chk("st.tack", 32'(TACK_OUT),  32'h1);
    TSn = 1'b1; tick();
    chk_idle("st.after");

    // 5: async reset mid-DRIVE
    REQ = 8'h01; tick();
    REQ = 8'h00;
    chk("t5.pre", 32'(TACK_OE), 32'h1);
    #3 DELAYED_TACK_RST = 1'b1;
    #1;
    chk_idle("t5.async");
    chk("t5.cnt", 32'(COLL_CNT), 32'h0);
    tick();
    DELAYED_TACK_RST = 1'b0;
    tick();
    chk_idle("t5.idle");

    // 6: saturating collision counter
    for (int i = 0; i < 300; i++) begin
      REQ = 8'h03; tick();
      REQ = 8'h00; repeat (3) tick();
    end
    chk("t6.sat", 32'(COLL_CNT), 32'd255);
    REQ = 8'h03; tick();
    chk("t6.hold", 32'(COLL_CNT), 32'd255);
    chk("t6.coll", 32'(COLLISION), 32'h1);
    REQ = 8'h00; repeat (3) tick();

    // Requester 7: bus error with TEA, normal non-cacheable TACK without
    REQ = 8'h80; tick();
    chk("t7.oe",  32'(TACK_OE), 32'h1);
    chk("t7.gnt", 32'(GRANT),   32'h80);
`ifdef U409_TACK_TEA_EN
    chk("t7.tea",  32'(TEA_OUT),  32'h0);
    chk("t7.tack", 32'(TACK_OUT), 32'h1);
    chk("t7.tci",  32'(TCI_OUT),  32'h1);
    REQ = 8'h00; tick();
    chk("t7.tea1", 32'(TEA_OUT),  32'h1);
`else
    chk("t7.tack", 32'(TACK_OUT), 32'h0);
    chk("t7.tci",  32'(TCI_OUT),  32'h0);
    REQ = 8'h00; tick();
    chk("t7.tack1", 32'(TACK_OUT), 32'h1);
`endif
    repeat (3) tick();
    chk_idle("t7.end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
